datmem_bytelane: RTL and testbench

- Parametrised successor to the single-word data memory for the MEM stage.
- Adds RV32 byte, halfword and word stores using byte-lane write enables.
- Adds signed and unsigned load extraction, alignment and size fault detection, and a valid/ready request port.
- Adds configurable read latency and a post-reset clear sequencer that zeroes the array before the memory accepts traffic.

---
 rtl/datmem_bytelane_pkg.sv | 50 +++++
 rtl/datmem_bytelane_if.sv | 25 ++
 rtl/datmem_bytelane_lane_fmt.sv | 51 +++++
 rtl/datmem_bytelane.sv | 128 ++++++++++++
 tb/tb_datmem_bytelane.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/datmem_bytelane_pkg.sv
// datmem_pkg: shared definitions for the byte-lane data memory.
//   - RV32 funct3 load/store size codes
//   - state_t for the clear sequencer (INIT -> RUN)
//   - lane_ctl(): byte-lane write mask and fault flag from size, addr[1:0], we
package datmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic [3:0] mask;
        logic       fault;
    } lane_ctl_t;

    // Mask is only non-zero for a legal store; loads and faults never write.
    function automatic lane_ctl_t lane_ctl(input logic [2:0] size,
                                           input logic [1:0] lo,
                                           input logic       we);
        lane_ctl_t c;
        c.mask  = '0;
        c.fault = 1'b0;
        case (size)
            SZ_B:  c.mask = 4'b0001 << lo;
            SZ_H: begin
                c.fault = lo[0];
                c.mask  = lo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_W: begin
                c.fault = (lo != 2'b00);
                c.mask  = '1;
            end
            SZ_BU: c.fault = we;
            SZ_HU: c.fault = we | lo[0];
            default: c.fault = 1'b1;
        endcase
        if (!we || c.fault) begin
            c.mask = '0;
        end
        return c;
    endfunction

endpackage

// File: rtl/datmem_bytelane_if.sv
// datmem_bytelane_if: request/response bus of the MEM-stage data memory.
//   req_valid/req_ready handshake, req_we, req_size (funct3), req_addr,
//   req_wdata; rsp_valid strobe with rsp_rdata and rsp_fault.
//   master: the requester (pipeline / bench); slave: the memory.
interface datmem_bytelane_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/datmem_bytelane_lane_fmt.sv
// datmem_lane_fmt: combinational lane formatter.
//   in : size (funct3), addr_lo (addr[1:0]), we, wdata (right-justified),
//        rword (raw array word at the request index)
//   out: wmask (byte-lane enables), wdata_rep (replicated store data),
//        rdata (extended load data, 0 for stores/faults), fault
module datmem_lane_fmt
    import datmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata,
    output logic        fault
);

    lane_ctl_t   ctl;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        ctl   = lane_ctl(size, addr_lo, we);
        wmask = ctl.mask;
        fault = ctl.fault;

        case (size)
            SZ_B, SZ_BU: wdata_rep = {4{wdata[7:0]}};
            SZ_H, SZ_HU: wdata_rep = {2{wdata[15:0]}};
            default:     wdata_rep = wdata;
        endcase

        byte_sel = rword[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

        case (size)
            SZ_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   rdata = {24'h000000, byte_sel};
            SZ_H:    rdata = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   rdata = {16'h0000, half_sel};
            SZ_W:    rdata = rword;
            default: rdata = '0;
        endcase
        if (we || ctl.fault) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/datmem_bytelane.sv
// datmem_bytelane: MEM-stage data memory with RV32 byte/half/word access.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : valid/ready request port and response strobe
//   init_done    : post-reset clear sequence finished, traffic accepted
// Parameters: WORDS (power of two >= 4), RD_LAT (1 or 2), CLEAR_ON_RESET.
module datmem_bytelane
    import datmem_pkg::*;
#(
    parameter int unsigned WORDS          = 256,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    datmem_bytelane_if.slave   bus,
    output logic               init_done
);

    localparam int unsigned IDX_W = $clog2(WORDS);

    logic [31:0]      mem [WORDS];
    state_t           state, state_nx;
    logic [IDX_W-1:0] clr_idx;
    logic             ready;
    logic             accept;
    logic [IDX_W-1:0] idx;

    logic [3:0]       wmask;
    logic [31:0]      wdata_rep;
    logic [31:0]      fmt_rdata;
    logic             fmt_fault;

    // Response pipeline; stage RD_LAT-1 drives the bus.
    logic [RD_LAT-1:0] pv;
    logic [31:0]       pd [RD_LAT];
    logic [RD_LAT-1:0] pf;

    // Upper address bits deliberately ignored: addresses wrap modulo WORDS*4.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:IDX_W+2];

    assign idx    = bus.req_addr[IDX_W+1:2];
    assign accept = bus.req_valid & ready;

    datmem_lane_fmt u_fmt (
        .size      (bus.req_size),
        .addr_lo   (bus.req_addr[1:0]),
        .we        (bus.req_we),
        .wdata     (bus.req_wdata),
        .rword     (mem[idx]),
        .wmask     (wmask),
        .wdata_rep (wdata_rep),
        .rdata     (fmt_rdata),
        .fault     (fmt_fault)
    );

    // ---------------- clear sequencer FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            clr_idx <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        case (state)
            INIT: begin
                if (CLEAR_ON_RESET == 0 || clr_idx == IDX_W'(WORDS - 1)) begin
                    state_nx = RUN;
                end
            end
            RUN: ready = 1'b1;
            default: state_nx = INIT;
        endcase
    end

    assign bus.req_ready = ready;
    assign init_done     = ready;

    // ---------------- array ----------------
    // Load data is taken from this array combinationally and captured on the
    // accept edge, so a store on edge N is visible to a load accepted on N+1.
    always_ff @(posedge clk) begin
        if (CLEAR_ON_RESET != 0 && state == INIT) begin
            mem[clr_idx] <= '0;
        end else if (accept) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- response pipeline ----------------
    // Data/fault stages are zeroed when their valid is low so idle outputs
    // read 0 without extra output gating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pf <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= accept;
            pf[0] <= accept & fmt_fault;
            pd[0] <= accept ? fmt_rdata : '0;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pf[i] <= pf[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign bus.rsp_valid = pv[RD_LAT-1];
    assign bus.rsp_fault = pf[RD_LAT-1];
    assign bus.rsp_rdata = pd[RD_LAT-1];

endmodule

// File: tb/tb_datmem_bytelane.sv
// tb_datmem_bytelane: directed, table-driven bench for datmem_bytelane.
//   u1: WORDS=256, RD_LAT=1; u2: WORDS=256, RD_LAT=2 (same stimulus);
//   u3: WORDS=4, CLEAR_ON_RESET=0 (idle, readiness after reset only).
module tb_datmem_bytelane;

    logic clk;
    logic rst_n;
    logic done1, done2, done3;

    int errors;
    int checks;

    datmem_bytelane_if b1 ();
    datmem_bytelane_if b2 ();
    datmem_bytelane_if b3 ();

    datmem_bytelane #(.WORDS(256), .RD_LAT(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .init_done(done1));
    datmem_bytelane #(.WORDS(256), .RD_LAT(2), .CLEAR_ON_RESET(1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2), .init_done(done2));
    datmem_bytelane #(.WORDS(4), .RD_LAT(1), .CLEAR_ON_RESET(0)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(b3), .init_done(done3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        b1.req_valid = v;  b2.req_valid = v;
        b1.req_we    = we; b2.req_we    = we;
        b1.req_size  = size;  b2.req_size  = size;
        b1.req_addr  = addr;  b2.req_addr  = addr;
        b1.req_wdata = wdata; b2.req_wdata = wdata;
    endtask

    // One request to both memories; checks latency, data, fault, idle zeros.
    task automatic xact(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] er, input logic ef,
                        input string tag);
        @(negedge clk);
        drive(1'b1, we, size, addr, wdata);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check({tag, " u1.valid"}, 32'(b1.rsp_valid), 32'd1);
        check({tag, " u1.rdata"}, b1.rsp_rdata, er);
        check({tag, " u1.fault"}, 32'(b1.rsp_fault), 32'(ef));
        check({tag, " u2.early"}, 32'(b2.rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, " u2.valid"}, 32'(b2.rsp_valid), 32'd1);
        check({tag, " u2.rdata"}, b2.rsp_rdata, er);
        check({tag, " u2.fault"}, 32'(b2.rsp_fault), 32'(ef));
        check({tag, " u1.idle"}, {b1.rsp_rdata[31:1], b1.rsp_valid | b1.rsp_fault}, 32'd0);
    endtask

    // Call right after releasing rst_n on a negedge.
    task automatic wait_init(input string tag);
        int   n;
        logic saw;
        logic r3;
        n   = 0;
        saw = 1'b0;
        r3  = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) r3 = b3.req_ready;
            if (b1.rsp_valid || b2.rsp_valid) saw = 1'b1;
        end while (!b1.req_ready && n < 400);
        check({tag, " init cycles"}, n, 32'd256);
        check({tag, " no rsp in init"}, 32'(saw), 32'd0);
        check({tag, " init_done u1"}, 32'(done1), 32'd1);
        check({tag, " ready u2"}, {31'd0, b2.req_ready & done2}, 32'd1);
        check({tag, " u3 ready 1st clk"}, {31'd0, r3 & done3}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

    logic [31:0] seq_addr [5];
    logic        seq_we   [5];
    logic [31:0] seq_exp  [5];

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        b3.req_valid = 1'b0;
        b3.req_we    = 1'b0;
        b3.req_size  = 3'b000;
        b3.req_addr  = 32'h0;
        b3.req_wdata = 32'h0;

        //          we    size    addr         wdata         rdata         fault
        vecs[0]  = '{1'b0, 3'b010, 32'h000003FC, 32'h00000000, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 3'b010, 32'h00000080, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b1, 3'b000, 32'h00000081, 32'h00000012, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 3'b010, 32'h00000080, 32'h00000000, 32'hDEAD12EF, 1'b0};
        vecs[4]  = '{1'b0, 3'b000, 32'h00000081, 32'h00000000, 32'h00000012, 1'b0};
        vecs[5]  = '{1'b0, 3'b100, 32'h00000083, 32'h00000000, 32'h000000DE, 1'b0};
        vecs[6]  = '{1'b0, 3'b001, 32'h00000082, 32'h00000000, 32'hFFFFDEAD, 1'b0};
        vecs[7]  = '{1'b0, 3'b101, 32'h00000082, 32'h00000000, 32'h0000DEAD, 1'b0};
        vecs[8]  = '{1'b0, 3'b000, 32'h00000080, 32'h00000000, 32'hFFFFFFEF, 1'b0};
        vecs[9]  = '{1'b1, 3'b010, 32'h00000084, 32'hCAFEF00D, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 3'b010, 32'h00000082, 32'h00000000, 32'h00000000, 1'b1};
        vecs[11] = '{1'b1, 3'b001, 32'h00000085, 32'h0000FFFF, 32'h00000000, 1'b1};
        vecs[12] = '{1'b0, 3'b010, 32'h00000084, 32'h00000000, 32'hCAFEF00D, 1'b0};
        vecs[13] = '{1'b0, 3'b011, 32'h00000084, 32'h00000000, 32'h00000000, 1'b1};
        vecs[14] = '{1'b1, 3'b100, 32'h00000084, 32'h000000AA, 32'h00000000, 1'b1};
        vecs[15] = '{1'b0, 3'b110, 32'h00000084, 32'h00000000, 32'h00000000, 1'b1};
        vecs[16] = '{1'b1, 3'b111, 32'h00000084, 32'h55555555, 32'h00000000, 1'b1};
        vecs[17] = '{1'b0, 3'b010, 32'h00000084, 32'h00000000, 32'hCAFEF00D, 1'b0};
        vecs[18] = '{1'b1, 3'b001, 32'h00000086, 32'h00001234, 32'h00000000, 1'b0};
        vecs[19] = '{1'b0, 3'b010, 32'h00000084, 32'h00000000, 32'h1234F00D, 1'b0};
        vecs[20] = '{1'b1, 3'b010, 32'h00000400, 32'h11111111, 32'h00000000, 1'b0};
        vecs[21] = '{1'b0, 3'b010, 32'h00000000, 32'h00000000, 32'h11111111, 1'b0};
        vecs[22] = '{1'b0, 3'b001, 32'h00000083, 32'h00000000, 32'h00000000, 1'b1};
        vecs[23] = '{1'b0, 3'b101, 32'h00000081, 32'h00000000, 32'h00000000, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst u1.ready", 32'(b1.req_ready), 32'd0);
        check("rst u1.init_done", 32'(done1), 32'd0);
        check("rst u2.ready", 32'(b2.req_ready), 32'd0);
        check("rst u3.ready", 32'(b3.req_ready), 32'd0);
        check("rst rsp", {b1.rsp_rdata | b2.rsp_rdata},
              32'd0);
        check("rst flags", {28'd0, b1.rsp_valid, b1.rsp_fault, b2.rsp_valid, b2.rsp_fault},
              32'd0);

        rst_n = 1'b1;
        wait_init("boot");

        for (int i = 0; i < 24; i++) begin
            xact(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                 vecs[i].rdata, vecs[i].fault, $sformatf("vec%0d", i));
        end

        // Back-to-back: store then load of the same word, then 3 more loads.
        seq_we[0] = 1'b1; seq_addr[0] = 32'h00000090; seq_exp[0] = 32'h00000000;
        seq_we[1] = 1'b0; seq_addr[1] = 32'h00000090; seq_exp[1] = 32'hA5A5A5A5;
        seq_we[2] = 1'b0; seq_addr[2] = 32'h00000080; seq_exp[2] = 32'hDEAD12EF;
        seq_we[3] = 1'b0; seq_addr[3] = 32'h00000084; seq_exp[3] = 32'h1234F00D;
        seq_we[4] = 1'b0; seq_addr[4] = 32'h00000000; seq_exp[4] = 32'h11111111;
        for (int j = 0; j < 8; j++) begin
            logic        v1, v2;
            logic [31:0] d1, d2;
            @(negedge clk);
            v1 = (j >= 1 && j <= 5);
            v2 = (j >= 2 && j <= 6);
            d1 = v1 ? seq_exp[j-1] : 32'h0;
            d2 = v2 ? seq_exp[j-2] : 32'h0;
            check($sformatf("b2b%0d u1.valid", j), 32'(b1.rsp_valid), 32'(v1));
            check($sformatf("b2b%0d u1.rdata", j), b1.rsp_rdata, d1);
            check($sformatf("b2b%0d u2.valid", j), 32'(b2.rsp_valid), 32'(v2));
            check($sformatf("b2b%0d u2.rdata", j), b2.rsp_rdata, d2);
            if (j < 5) drive(1'b1, seq_we[j], 3'b010, seq_addr[j], 32'hA5A5A5A5);
            else       drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        end

        // Reset pulsed with a load in flight
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h00000080, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midrst%0d valid", k), {30'd0, b1.rsp_valid, b2.rsp_valid}, 32'd0);
            check($sformatf("midrst%0d ready", k), {29'd0, b1.req_ready, b2.req_ready, done1}, 32'd0);
        end
        rst_n = 1'b1;
        wait_init("rerun");
        xact(1'b0, 3'b010, 32'h00000080, 32'h0, 32'h00000000, 1'b0, "post-rst lw80");
        xact(1'b0, 3'b010, 32'h00000000, 32'h0, 32'h00000000, 1'b0, "post-rst lw00");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
